// File: rtl/parking_gate_ctrl.sv
// Parking lot gate controller: independent entry/exit barrier FSMs with occupancy tracking; GATE_TIMEOUT_EN adds an open-gate timeout.
// All outputs registered (one-cycle latency from request/pass); no backpressure, requests are levels and passes are pulses.
module parking_gate_ctrl #(
  parameter int MAX_CARS       = 10,
  parameter int CLOSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       entry_pass,
  input  logic       exit_pass,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic [3:0] occupancy,
  output logic       full,
  output logic       empty,
  output logic       entry_denied,
  output logic       gate_timeout
);

  if (MAX_CARS < 1 || MAX_CARS > 15 || CLOSE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("parking_gate_ctrl: parameter out of range");
  end

  localparam int         CW      = $clog2(CLOSE_CYCLES + 1);
  localparam logic [3:0] MAX_OCC = 4'(MAX_CARS);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSING} gate_state_t;

  gate_state_t   en_state, en_state_nxt, ex_state, ex_state_nxt;
  logic [CW-1:0] en_hold, en_hold_nxt, ex_hold, ex_hold_nxt;
  logic [CW-1:0] deny_wait, deny_wait_nxt;
  logic [3:0]    occ_nxt;
  logic          denied_nxt;
  logic          en_pass_ok, ex_pass_ok;

`ifdef GATE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] en_tmo, en_tmo_nxt, ex_tmo, ex_tmo_nxt;
  logic          timeout_nxt;
`endif

  // Passes only count while the matching gate is actually open.
  assign en_pass_ok = (en_state == OPEN) && entry_pass;
  assign ex_pass_ok = (ex_state == OPEN) && exit_pass;

  always_comb begin
    occ_nxt = occupancy;
    if (en_pass_ok && !ex_pass_ok && occupancy < MAX_OCC) occ_nxt = occupancy + 4'd1;
    else if (ex_pass_ok && !en_pass_ok && occupancy != 4'd0) occ_nxt = occupancy - 4'd1;
  end

  always_comb begin
    en_state_nxt  = en_state;
    en_hold_nxt   = en_hold;
    ex_state_nxt  = ex_state;
    ex_hold_nxt   = ex_hold;
    deny_wait_nxt = deny_wait;
    denied_nxt    = 1'b0;
`ifdef GATE_TIMEOUT_EN
    en_tmo_nxt    = en_tmo;
    ex_tmo_nxt    = ex_tmo;
    timeout_nxt   = 1'b0;
`endif
    if (deny_wait != '0) deny_wait_nxt = deny_wait - 1'b1;

    case (en_state)
      IDLE: begin
        if (!entry_req) begin
          deny_wait_nxt = '0;
        end else if (!full) begin
          en_state_nxt = OPEN;
`ifdef GATE_TIMEOUT_EN
          en_tmo_nxt = TW'(TIMEOUT_CYCLES - 1);
`endif
        end else if (deny_wait == '0) begin
          // Cool-down spaces repeated refusals one gate cycle apart.
          denied_nxt    = 1'b1;
          deny_wait_nxt = CW'(CLOSE_CYCLES);
        end
      end
      OPEN: begin
        if (entry_pass) begin
          en_state_nxt = CLOSING;
          en_hold_nxt  = CW'(CLOSE_CYCLES - 1);
        end
`ifdef GATE_TIMEOUT_EN
        else if (en_tmo == '0) begin
          en_state_nxt = CLOSING;
          en_hold_nxt  = CW'(CLOSE_CYCLES - 1);
          timeout_nxt  = 1'b1;
        end else begin
          en_tmo_nxt = en_tmo - 1'b1;
        end
`endif
      end
      CLOSING: begin
        if (en_hold == '0) en_state_nxt = IDLE;
        else               en_hold_nxt  = en_hold - 1'b1;
      end
      default: en_state_nxt = IDLE;
    endcase

    case (ex_state)
      IDLE: begin
        if (exit_req && !empty) begin
          ex_state_nxt = OPEN;
`ifdef GATE_TIMEOUT_EN
          ex_tmo_nxt = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      OPEN: begin
        if (exit_pass) begin
          ex_state_nxt = CLOSING;
          ex_hold_nxt  = CW'(CLOSE_CYCLES - 1);
        end
`ifdef GATE_TIMEOUT_EN
        else if (ex_tmo == '0) begin
          ex_state_nxt = CLOSING;
          ex_hold_nxt  = CW'(CLOSE_CYCLES - 1);
          timeout_nxt  = 1'b1;
        end else begin
          ex_tmo_nxt = ex_tmo - 1'b1;
        end
`endif
      end
      CLOSING: begin
        if (ex_hold == '0) ex_state_nxt = IDLE;
        else               ex_hold_nxt  = ex_hold - 1'b1;
      end
      default: ex_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_state        <= IDLE;
      ex_state        <= IDLE;
      en_hold         <= '0;
      ex_hold         <= '0;
      deny_wait       <= '0;
      occupancy       <= 4'd0;
      full            <= 1'b0;
      empty           <= 1'b1;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      entry_denied    <= 1'b0;
    end else begin
      en_state        <= en_state_nxt;
      ex_state        <= ex_state_nxt;
      en_hold         <= en_hold_nxt;
      ex_hold         <= ex_hold_nxt;
      deny_wait       <= deny_wait_nxt;
      occupancy       <= occ_nxt;
      full            <= (occ_nxt == MAX_OCC);
      empty           <= (occ_nxt == 4'd0);
      entry_gate_open <= (en_state_nxt == OPEN);
      exit_gate_open  <= (ex_state_nxt == OPEN);
      entry_denied    <= denied_nxt;
    end
  end

`ifdef GATE_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_tmo       <= '0;
      ex_tmo       <= '0;
      gate_timeout <= 1'b0;
    end else begin
      en_tmo       <= en_tmo_nxt;
      ex_tmo       <= ex_tmo_nxt;
      gate_timeout <= timeout_nxt;
    end
  end
`else
  assign gate_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed, table-driven bench for parking_gate_ctrl with default parameters.
module tb_parking_gate_ctrl;
  localparam int CLOSE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req, exit_req, entry_pass, exit_pass;
  logic       entry_gate_open, exit_gate_open, full, empty, entry_denied, gate_timeout;
  logic [3:0] occupancy;

  int checks = 0;
  int errors = 0;

  parking_gate_ctrl #(.MAX_CARS(10), .CLOSE_CYCLES(CLOSE), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .entry_req(entry_req), .exit_req(exit_req),
    .entry_pass(entry_pass), .exit_pass(exit_pass),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .occupancy(occupancy), .full(full), .empty(empty),
    .entry_denied(entry_denied), .gate_timeout(gate_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       er, xr, ep, xp;
    logic       eo, xo;
    logic [3:0] occ;
    logic       fu, em, dn;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic [3:0] ins, input logic eo, input logic xo,
                              input logic [3:0] occ, input logic fu, input logic em, input logic dn);
    vec_t v;
    v.er = ins[3]; v.xr = ins[2]; v.ep = ins[1]; v.xp = ins[0];
    v.eo = eo; v.xo = xo; v.occ = occ; v.fu = fu; v.em = em; v.dn = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gate(input bit is_entry);
    int n = 0;
    while ((is_entry ? entry_gate_open : exit_gate_open) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(is_entry ? "entry_open_wait" : "exit_open_wait", 32'(n < 20), 32'd1);
  endtask

  task automatic enter_car(input logic [3:0] exp_occ);
    entry_req = 1'b1;
    wait_gate(1'b1);
    entry_req  = 1'b0;
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    check("enter_occ", occupancy, exp_occ);
    repeat (CLOSE) tick();
  endtask

  task automatic leave_car(input logic [3:0] exp_occ);
    exit_req = 1'b1;
    wait_gate(1'b0);
    exit_req  = 1'b0;
    exit_pass = 1'b1;
    tick();
    exit_pass = 1'b0;
    check("leave_occ", occupancy, exp_occ);
    repeat (CLOSE) tick();
  endtask

  initial begin
    int last, pulses, open_cnt, tmo_cnt;

    // {entry_req, exit_req, entry_pass, exit_pass} -> en_open, ex_open, occ, full, empty, denied
    vecs[0] = mk(4'b1000, 1, 0, 0, 0, 1, 0);
    vecs[1] = mk(4'b0000, 1, 0, 0, 0, 1, 0);
    vecs[2] = mk(4'b0000, 1, 0, 0, 0, 1, 0);
    vecs[3] = mk(4'b0010, 0, 0, 1, 0, 0, 0);
    for (int i = 4; i < 8; i++) vecs[i] = mk(4'b1000, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(4'b1000, 1, 0, 1, 0, 0, 0);
    vecs[9]  = mk(4'b1010, 0, 0, 2, 0, 0, 0);
    vecs[10] = mk(4'b0010, 0, 0, 2, 0, 0, 0);
    vecs[11] = mk(4'b0100, 0, 1, 2, 0, 0, 0);
    vecs[12] = mk(4'b0001, 0, 0, 1, 0, 0, 0);
    vecs[13] = mk(4'b0001, 0, 0, 1, 0, 0, 0);
    for (int i = 14; i < 17; i++) vecs[i] = mk(4'b0100, 0, 0, 1, 0, 0, 0);
    vecs[17] = mk(4'b0100, 0, 1, 1, 0, 0, 0);
    vecs[18] = mk(4'b0001, 0, 0, 0, 0, 1, 0);
    for (int i = 19; i < 25; i++) vecs[i] = mk(4'b0110, 0, 0, 0, 0, 1, 0);

    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; entry_pass = 1'b0; exit_pass = 1'b0;
    tick(); tick();
    check("rst_en_open", entry_gate_open, 0);
    check("rst_ex_open", exit_gate_open, 0);
    check("rst_occ", occupancy, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_denied", entry_denied, 0);
    check("rst_timeout", gate_timeout, 0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      entry_req = vecs[i].er; exit_req = vecs[i].xr;
      entry_pass = vecs[i].ep; exit_pass = vecs[i].xp;
      tick();
      check($sformatf("vec%0d_en_open", i), entry_gate_open, vecs[i].eo);
      check($sformatf("vec%0d_ex_open", i), exit_gate_open, vecs[i].xo);
      check($sformatf("vec%0d_occ", i), occupancy, vecs[i].occ);
      check($sformatf("vec%0d_full", i), full, vecs[i].fu);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].em);
      check($sformatf("vec%0d_denied", i), entry_denied, vecs[i].dn);
    end
    entry_req = 1'b0; exit_req = 1'b0; entry_pass = 1'b0; exit_pass = 1'b0;
    repeat (CLOSE + 1) tick();

    // Fill the lot, then hold a request against a full lot.
    for (int k = 1; k <= 10; k++) enter_car(4'(k));
    check("fill_full", full, 1);
    entry_req = 1'b1;
    last = -1; pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (entry_gate_open !== 1'b0) check("full_gate_closed", entry_gate_open, 0);
      if (entry_denied === 1'b1) begin
        if (last >= 0) check("deny_period", 32'(c - last), 5);
        last = c;
        pulses++;
      end
    end
    check("deny_pulses", 32'(pulses), 6);
    entry_req = 1'b0;
    tick();

    for (int k = 9; k >= 5; k--) leave_car(4'(k));

    // Simultaneous passes with both gates open.
    entry_req = 1'b1; exit_req = 1'b1;
    tick();
    check("both_en_open", entry_gate_open, 1);
    check("both_ex_open", exit_gate_open, 1);
    entry_pass = 1'b1; exit_pass = 1'b1;
    tick();
    entry_pass = 1'b0; exit_pass = 1'b0;
    check("both_pass_occ", occupancy, 5);
    check("both_pass_en", entry_gate_open, 0);
    check("both_pass_ex", exit_gate_open, 0);
    repeat (CLOSE) tick();
    check("both_closing_en", entry_gate_open, 0);
    check("both_closing_ex", exit_gate_open, 0);
    tick();
    check("both_reopen_en", entry_gate_open, 1);
    check("both_reopen_ex", exit_gate_open, 1);
    entry_req = 1'b0; exit_req = 1'b0;

    // Bring occupancy to 7 with the exit gate still open, then reset asynchronously.
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    check("occ6", occupancy, 6);
    repeat (CLOSE) tick();
    enter_car(4'd7);
    check("pre_rst_ex_open", exit_gate_open, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_occ", occupancy, 0);
    check("arst_ex_open", exit_gate_open, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);

    // Grant only after release, then check open-gate timeout behaviour.
    entry_req = 1'b1;
    tick();
    check("in_rst_no_grant", entry_gate_open, 0);
    reset = 1'b0;
    check("release_no_grant", entry_gate_open, 0);
    tick();
    check("post_rst_grant", entry_gate_open, 1);
    entry_req = 1'b0;
    open_cnt = 1; tmo_cnt = 0;
    for (int c = 1; c < 100; c++) begin
      tick();
      if (entry_gate_open === 1'b1) open_cnt++;
      if (gate_timeout === 1'b1) tmo_cnt++;
    end
`ifdef GATE_TIMEOUT_EN
    check("tmo_open_cycles", 32'(open_cnt), 64);
    check("tmo_pulses", 32'(tmo_cnt), 1);
    check("tmo_gate_closed", entry_gate_open, 0);
`else
    check("no_tmo_open_cycles", 32'(open_cnt), 100);
    check("no_tmo_pulses", 32'(tmo_cnt), 0);
    check("no_tmo_gate_open", entry_gate_open, 1);
`endif
    check("tmo_occ", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 SHALL have parameter MAX_CARS, default 10, giving lot capacity (1..15).
REQ-002 SHALL have parameter CLOSE_CYCLES, default 4, giving the gate-closing hold time in clk cycles (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the open-gate timeout in clk cycles (>=1); used only under GATE_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port entry_req  input  1  car waiting at the entry gate (level).
REQ-007 SHALL have port exit_req  input  1  car waiting at the exit gate (level).
REQ-008 SHALL have port entry_pass  input  1  entry-gate pass sensor, one-cycle pulse.
REQ-009 SHALL have port exit_pass  input  1  exit-gate pass sensor, one-cycle pulse.
REQ-010 SHALL have port entry_gate_open  output  1  entry barrier raise command.
REQ-011 SHALL have port exit_gate_open  output  1  exit barrier raise command.
REQ-012 SHALL have port occupancy  output  4  cars currently in the lot.
REQ-013 SHALL have port full  output  1  high when occupancy == MAX_CARS.
REQ-014 SHALL have port empty  output  1  high when occupancy == 0.
REQ-015 SHALL have port entry_denied  output  1  one-cycle pulse: entry refused because full.
REQ-016 SHALL have port gate_timeout  output  1  one-cycle pulse: a gate closed on timeout.

Function
REQ-017 Each gate SHALL have an independent FSM with states IDLE, OPEN and CLOSING; all outputs SHALL be registered.
REQ-018 Entry IDLE with entry_req=1 and full=0 SHALL go to OPEN; entry_gate_open SHALL be 1 from the next cycle for as long as the FSM is in OPEN.
REQ-019 Entry IDLE with entry_req=1 and full=1 SHALL stay in IDLE and pulse entry_denied for one cycle; while the request persists, the pulse SHALL repeat every CLOSE_CYCLES+1 cycles.
REQ-020 Exit IDLE with exit_req=1 and empty=0 SHALL go to OPEN; exit_req while empty=1 SHALL be ignored.
REQ-021 In OPEN, a pass pulse SHALL move the FSM to CLOSING and update occupancy on the same edge: +1 on entry, -1 on exit.
REQ-022 CLOSING SHALL hold the gate closed for exactly CLOSE_CYCLES cycles, then go to IDLE; requests SHALL NOT be granted during CLOSING.
REQ-023 A pass pulse received while a gate is not in OPEN SHALL be ignored; occupancy SHALL be unchanged.
REQ-024 Entry and exit passes on the same edge SHALL leave occupancy unchanged.
REQ-025 occupancy SHALL never exceed MAX_CARS or go below 0; full and empty SHALL be derived from the next occupancy value so that they update on the same edge as occupancy.
REQ-026 An exit pass while the entry gate is OPEN at occupancy == MAX_CARS-1 SHALL be counted normally; the entry grant SHALL remain valid.

Reset
REQ-027 While reset=1: both FSMs SHALL be IDLE, occupancy=0, full=0, empty=1, and both gates, entry_denied and gate_timeout SHALL be 0; this applies immediately, including mid-OPEN or mid-CLOSING.
REQ-028 After reset is released, the first grant SHALL occur no earlier than the first rising edge at which reset=0.

Configuration
REQ-029 Macro GATE_TIMEOUT_EN, when defined, SHALL add a per-gate counter: OPEN with no pass for TIMEOUT_CYCLES cycles goes to CLOSING, occupancy unchanged, and gate_timeout pulses for one cycle.
REQ-030 Without GATE_TIMEOUT_EN, OPEN SHALL persist until a pass pulse arrives, and gate_timeout SHALL be tied to 0.

Verification
REQ-031 Reset, then entry_req with entry_pass 3 cycles later -> entry_gate_open=1 for 3 cycles, occupancy 0->1, empty 1->0, gate closed for 4 cycles, then IDLE.
REQ-032 Ten entries, then entry_req held -> occupancy=10, full=1, entry_gate_open stays 0, entry_denied pulses repeat every 5 cycles.
REQ-033 At occupancy=5, entry_pass and exit_pass on the same edge with both gates OPEN -> occupancy stays 5, both FSMs go to CLOSING.
REQ-034 exit_req at occupancy=0, and a stray entry_pass while entry is IDLE -> no gate opens, occupancy stays 0.
REQ-035 With GATE_TIMEOUT_EN, entry OPEN for 64 cycles with no pass -> gate_timeout pulse, gate closes, occupancy unchanged; without the macro -> gate still open at cycle 100.
REQ-036 Assert reset while the exit gate is OPEN at occupancy=7 -> occupancy=0, exit_gate_open=0, empty=1 with no clock edge required.
